// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   usr_mode_e : operation select encoding for the 3-bit mode input
//   cnt_width  : width of a counter that must hold values 0..w
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD = 3'b000,
        USR_SHR  = 3'b001,
        USR_SHL  = 3'b010,
        USR_ROR  = 3'b011,
        USR_ROL  = 3'b100,
        USR_ASR  = 3'b101,
        USR_LOAD = 3'b110,
        USR_RSVD = 3'b111
    } usr_mode_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/usr_next_mux.sv
// Combinational next-state selection for the universal shift register.
// It only decides what the register would become for a given mode. Clear,
// enable and reset priority are applied by the register stage in the top.
// Ports:
//   mode      in   3      operation select (usr_mode_e encoding)
//   q         in   WIDTH  current register contents
//   d         in   WIDTH  parallel load data
//   sin_msb   in   1      serial in for bit WIDTH-1 on SHR
//   sin_lsb   in   1      serial in for bit 0 on SHL
//   cnt       in   CW     current shift count
//   q_next    out  WIDTH  next register contents
//   cnt_next  out  CW     next shift count
//   err_next  out  1      1 when mode is the reserved encoding
module usr_next_mux
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [CW-1:0]    cnt,
    output logic [WIDTH-1:0] q_next,
    output logic [CW-1:0]    cnt_next,
    output logic             err_next
);

    usr_mode_e     mode_e;
    logic [CW-1:0] cnt_inc;

    assign mode_e = usr_mode_e'(mode);

    // Saturate at WIDTH so that drained stays asserted until the next load.
    assign cnt_inc = (cnt == CW'(WIDTH)) ? cnt : cnt + CW'(1);

    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        err_next = 1'b0;
        case (mode_e)
            USR_HOLD: begin
                q_next = q;
            end
            USR_SHR: begin
                q_next   = {sin_msb, q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            USR_SHL: begin
                q_next   = {q[WIDTH-2:0], sin_lsb};
                cnt_next = cnt_inc;
            end
            USR_ROR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            USR_ROL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                cnt_next = cnt_inc;
            end
            USR_ASR: begin
                q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            USR_LOAD: begin
                q_next   = d;
                cnt_next = '0;
            end
            USR_RSVD: begin
                err_next = 1'b1;
            end
            default: begin
                q_next = q;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, logical shift L/R, rotate L/R, arithmetic
// shift right and parallel load, with a count of shifts since the last load
// and a drained flag once every loaded bit has been shifted out.
// Ports:
//   clk          in   1      clock, rising edge
//   async_reset  in   1      asynchronous active-high reset, q <= RESET_VAL
//   en           in   1      clock enable; 0 holds q and shift_cnt
//   sync_clr     in   1      synchronous clear, beats en and mode
//   mode         in   3      operation select (usr_mode_e encoding)
//   d            in   WIDTH  parallel load data
//   sin_msb      in   1      serial in, enters bit WIDTH-1 on SHR
//   sin_lsb      in   1      serial in, enters bit 0 on SHL
//   q            out  WIDTH  register contents
//   sout_lsb     out  1      q[0]
//   sout_msb     out  1      q[WIDTH-1]
//   shift_cnt    out  CW     shifts since last load/clear/reset (saturating)
//   drained      out  1      shift_cnt == WIDTH
//   mode_err     out  1      one-cycle pulse after an enabled reserved mode
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CW-1:0]    shift_cnt,
    output logic             drained,
    output logic             mode_err
);

    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             err_next;

    usr_next_mux #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_next_mux (
        .mode     (mode),
        .q        (q),
        .d        (d),
        .sin_msb  (sin_msb),
        .sin_lsb  (sin_lsb),
        .cnt      (shift_cnt),
        .q_next   (q_next),
        .cnt_next (cnt_next),
        .err_next (err_next)
    );

    // Priority: reset > sync_clr > !en > mode. mode_err is a pulse, so every
    // path that does not take an enabled reserved mode drives it low.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            mode_err  <= 1'b0;
        end else if (sync_clr) begin
            q         <= '0;
            shift_cnt <= '0;
            mode_err  <= 1'b0;
        end else if (!en) begin
            mode_err  <= 1'b0;
        end else begin
            q         <= q_next;
            shift_cnt <= cnt_next;
            mode_err  <= err_next;
        end
    end

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];
    assign drained  = (shift_cnt == CW'(WIDTH));

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          async_reset;
    logic          en;
    logic          sync_clr;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin_msb;
    logic          sin_lsb;
    logic [W-1:0]  q;
    logic          sout_lsb;
    logic          sout_msb;
    logic [CW-1:0] shift_cnt;
    logic          drained;
    logic          mode_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         en;
        logic         clr;
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         smsb;
        logic         slsb;
        logic [W-1:0] eq;
        logic [CW-1:0] ec;
        logic         ed;
        logic         ee;
    } vec_t;

    vec_t vecs[$];

    universal_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .en          (en),
        .sync_clr    (sync_clr),
        .mode        (mode),
        .d           (d),
        .sin_msb     (sin_msb),
        .sin_lsb     (sin_lsb),
        .q           (q),
        .sout_lsb    (sout_lsb),
        .sout_msb    (sout_msb),
        .shift_cnt   (shift_cnt),
        .drained     (drained),
        .mode_err    (mode_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against one expected state; exp_q carries q.
    task automatic check_state(input string tag, input logic [CW-1:0] ec,
                               input logic ed, input logic ee);
        logic [W-1:0] eq;
        eq = exp_q.pop_front();
        check({tag, " q"}, 32'(q), 32'(eq));
        check({tag, " shift_cnt"}, 32'(shift_cnt), 32'(ec));
        check({tag, " drained"}, 32'(drained), 32'(ed));
        check({tag, " mode_err"}, 32'(mode_err), 32'(ee));
        check({tag, " sout_lsb"}, 32'(sout_lsb), 32'(eq[0]));
        check({tag, " sout_msb"}, 32'(sout_msb), 32'(eq[W-1]));
    endtask

    // Drive one cycle from the falling edge and sample 1 ns after the rise.
    task automatic drive(input logic e, input logic c, input logic [2:0] m,
                         input logic [W-1:0] dd, input logic sm, input logic sl);
        en       = e;
        sync_clr = c;
        mode     = m;
        d        = dd;
        sin_msb  = sm;
        sin_lsb  = sl;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(input logic e, input logic c, input logic [2:0] m,
                               input logic [W-1:0] dd, input logic sm, input logic sl,
                               input logic [W-1:0] eq, input logic [CW-1:0] ec,
                               input logic ee);
        vec_t r;
        r.en = e; r.clr = c; r.mode = m; r.d = dd; r.smsb = sm; r.slsb = sl;
        r.eq = eq; r.ec = ec; r.ed = (ec == CW'(8)); r.ee = ee;
        return r;
    endfunction

    initial begin
        logic [W-1:0] shr_exp[8];
        logic [W-1:0] rol_exp[8];

        shr_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
        rol_exp = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};

        // LOAD 81 then SHR x8 (sin_msb=0), then a 9th SHR that must saturate
        vecs.push_back(v(1, 0, USR_LOAD, 8'h81, 0, 0, 8'h81, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(v(1, 0, USR_SHR, 8'h00, 0, 0, shr_exp[i], CW'(i + 1), 0));
        vecs.push_back(v(1, 0, USR_SHR, 8'h00, 0, 0, 8'h00, 8, 0));
        // LOAD 96, ROL x8 back to 96
        vecs.push_back(v(1, 0, USR_LOAD, 8'h96, 0, 0, 8'h96, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(v(1, 0, USR_ROL, 8'h00, 0, 0, rol_exp[i], CW'(i + 1), 0));
        // LOAD 80, ASR x3 -> F0
        vecs.push_back(v(1, 0, USR_LOAD, 8'h80, 0, 0, 8'h80, 0, 0));
        vecs.push_back(v(1, 0, USR_ASR, 8'h00, 0, 0, 8'hC0, 1, 0));
        vecs.push_back(v(1, 0, USR_ASR, 8'h00, 0, 0, 8'hE0, 2, 0));
        vecs.push_back(v(1, 0, USR_ASR, 8'h00, 0, 0, 8'hF0, 3, 0));
        // en=0 with SHL for 5 edges holds everything
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, USR_SHL, 8'h00, 1, 1, 8'hF0, 3, 0));
        // sync_clr beats en=0 and LOAD
        vecs.push_back(v(0, 1, USR_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0));
        // reserved mode: one-cycle error pulse, q held
        vecs.push_back(v(1, 0, USR_LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0));
        vecs.push_back(v(1, 0, USR_RSVD, 8'hFF, 0, 0, 8'h3C, 0, 1));
        vecs.push_back(v(1, 0, USR_HOLD, 8'hFF, 0, 0, 8'h3C, 0, 0));
        vecs.push_back(v(0, 0, USR_RSVD, 8'hFF, 0, 0, 8'h3C, 0, 0));
        // SHL / ROR / SHR with serial ones, then HOLD
        vecs.push_back(v(1, 0, USR_SHL, 8'h00, 0, 1, 8'h79, 1, 0));
        vecs.push_back(v(1, 0, USR_ROR, 8'h00, 0, 0, 8'hBC, 2, 0));
        vecs.push_back(v(1, 0, USR_SHR, 8'h00, 1, 0, 8'hDE, 3, 0));
        vecs.push_back(v(1, 0, USR_HOLD, 8'h00, 0, 0, 8'hDE, 3, 0));
        vecs.push_back(v(1, 0, USR_SHL, 8'h00, 0, 0, 8'hBC, 4, 0));

        // reset block
        async_reset = 1'b1;
        en = 0; sync_clr = 0; mode = USR_HOLD; d = '0; sin_msb = 0; sin_lsb = 0;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'hA5);
        check_state("reset", 0, 0, 0);
        async_reset = 1'b0;
        @(negedge clk);

        // async reset asserted between edges acts immediately
        drive(1, 0, USR_LOAD, 8'h81, 0, 0);
        exp_q.push_back(8'h81);
        check_state("pre_async", 0, 0, 0);
        @(negedge clk);
        async_reset = 1'b1;
        #1;
        exp_q.push_back(8'hA5);
        check_state("async_mid", 0, 0, 0);
        #1;
        async_reset = 1'b0;
        @(negedge clk);

        // table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].d, vecs[i].smsb, vecs[i].slsb);
            exp_q.push_back(vecs[i].eq);
            check_state($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ed, vecs[i].ee);
            @(negedge clk);
        end

        // reset pulse mid-shift (shift_cnt=4 from the last vector), then SHL 1
        async_reset = 1'b1;
        #1;
        exp_q.push_back(8'hA5);
        check_state("reset_midshift", 0, 0, 0);
        #1;
        async_reset = 1'b0;
        drive(1, 0, USR_SHL, 8'h00, 0, 1);
        exp_q.push_back(8'h4B);
        check_state("post_reset_shl", 1, 0, 0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
